// File: rtl/commit_pkg.sv
// Shared definitions for the commit snoop table and its query-side issue block.
package commit_pkg;

    localparam int SNOOP_LINE_LSB = 6;
    localparam int ENTRY_TAG_W    = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHECK  = 2'd1,
        REPLAY = 2'd2,
        CLEAR  = 2'd3
    } state_t;

    typedef struct packed {
        logic [31:0]            addr;
        logic [ENTRY_TAG_W-1:0] tag;
    } entry_t;

endpackage

// File: rtl/commit_snoopissue_fifo.sv
// Generic circular FIFO with occupancy count and a single-cycle flush.
module commit_snoopissue_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 36
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         push_data,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign head    = mem[rd_ptr];
    assign count   = cnt;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            cnt <= cnt + CW'(push_ok) - CW'(pop_ok);
        end
    end

    // NOTE: storage is not reset; an entry is only ever read after it has been written.
    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/commit_snoopissue.sv
// Query-side snoop issue: buffers completed load addresses, queries the snoop
// table one per cycle, and on a hit requests a replay followed by a clear pulse.
module commit_snoopissue
    import commit_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int TAG_W = ENTRY_TAG_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enq_valid,
    output logic                   enq_ready,
    input  logic [31:0]            enq_addr,
    input  logic [TAG_W-1:0]       enq_tag,
    input  logic                   cancel,
    output logic [31:0]            q_addr,
    input  logic                   q_hit,
    output logic                   replay_valid,
    input  logic                   replay_ready,
    output logic [31:0]            replay_addr,
    output logic [TAG_W-1:0]       replay_tag,
    output logic                   en_clear,
    output logic [$clog2(DEPTH):0] count,
    output logic                   busy
);

    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [31:0]      addr;
        logic [TAG_W-1:0] tag;
    } slot_t;

    slot_t         push_slot;
    slot_t         head_slot;
    state_t        state;
    state_t        state_next;
    logic          push;
    logic          pop;
    logic          query;
    logic          full;
    logic          empty;
    logic [CW-1:0] cnt_after_pop;

    assign push_slot = '{addr: enq_addr, tag: enq_tag};

    // Enqueue is blocked while full even if the head pops this cycle.
    assign enq_ready = ~full;
    assign push      = enq_valid & enq_ready & ~cancel;
    assign query     = (state == CHECK) & ~empty;
    assign pop       = query & ~cancel;

    commit_snoopissue_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(slot_t))
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (cancel),
        .push      (push),
        .pop       (pop),
        .push_data (push_slot),
        .head      (head_slot),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    assign cnt_after_pop = count - CW'(1) + CW'(push);

    // NOTE: state_next gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:   if (!empty) state_next = CHECK;
            CHECK: begin
                if (empty)                   state_next = IDLE;
                else if (q_hit)              state_next = REPLAY;
                else if (cnt_after_pop == 0) state_next = IDLE;
            end
            REPLAY: if (replay_ready) state_next = CLEAR;
            CLEAR:  state_next = empty ? IDLE : CHECK;
            default: state_next = IDLE;
        endcase
        // A flush abandons any query, replay or pending clear.
        if (cancel) state_next = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            replay_addr <= '0;
            replay_tag  <= '0;
        end else if (query && q_hit && !cancel) begin
            replay_addr <= head_slot.addr;
            replay_tag  <= head_slot.tag;
        end
    end

    assign q_addr       = query ? head_slot.addr : '0;
    assign replay_valid = (state == REPLAY);
    assign en_clear     = (state == CLEAR);
    assign busy         = (state != IDLE) || !empty;

endmodule

// File: tb/tb_commit_snoopissue.sv
// Scoreboard bench for commit_snoopissue: directed stimulus queues expected
// queries/replays, a negedge monitor pops and compares them.
module tb_commit_snoopissue;

    localparam int DEPTH = 8;
    localparam int TAG_W = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             enq_valid;
    logic             enq_ready;
    logic [31:0]      enq_addr;
    logic [TAG_W-1:0] enq_tag;
    logic             cancel;
    logic [31:0]      q_addr;
    logic             q_hit;
    logic             replay_valid;
    logic             replay_ready;
    logic [31:0]      replay_addr;
    logic [TAG_W-1:0] replay_tag;
    logic             en_clear;
    logic [CW-1:0]    count;
    logic             busy;

    logic             hit_en;
    logic [31:0]      hit_addr;

    int checks     = 0;
    int errors     = 0;
    int clear_seen = 0;

    logic [31:0] exp_query  [$];
    logic [35:0] exp_replay [$];

    always #5 clk = ~clk;

    // Snoop table model: hits only on the one address selected by the test.
    assign q_hit = hit_en && (q_addr != 0) && (q_addr == hit_addr);

    commit_snoopissue #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enq_valid    (enq_valid),
        .enq_ready    (enq_ready),
        .enq_addr     (enq_addr),
        .enq_tag      (enq_tag),
        .cancel       (cancel),
        .q_addr       (q_addr),
        .q_hit        (q_hit),
        .replay_valid (replay_valid),
        .replay_ready (replay_ready),
        .replay_addr  (replay_addr),
        .replay_tag   (replay_tag),
        .en_clear     (en_clear),
        .count        (count),
        .busy         (busy)
    );

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (q_addr != 0) begin
                if (exp_query.size() == 0) check("query_unexpected", q_addr, 0);
                else                       check("query_order", q_addr, exp_query.pop_front());
            end
            if (replay_valid && replay_ready && !cancel) begin
                if (exp_replay.size() == 0) check("replay_unexpected", {replay_addr, replay_tag}, 0);
                else                        check("replay_data", {replay_addr, replay_tag}, exp_replay.pop_front());
            end
            if (en_clear) clear_seen++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_entry(input logic [31:0] a, input logic [TAG_W-1:0] t, input bit expect_query);
        int n;
        n = 0;
        enq_valid = 1'b1;
        enq_addr  = a;
        enq_tag   = t;
        while (!enq_ready && n < 50) begin
            tick();
            n++;
        end
        check("enq_ready_wait", enq_ready, 1);
        if (expect_query) exp_query.push_back(a);
        tick();
        enq_valid = 1'b0;
    endtask

    task automatic wait_replay();
        int n;
        n = 0;
        while (!replay_valid && n < 50) begin
            tick();
            n++;
        end
        check("replay_wait", replay_valid, 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        check("idle_wait", busy, 0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_enq_ready"},    enq_ready,    1);
        check({tag, "_count"},        count,        0);
        check({tag, "_busy"},         busy,         0);
        check({tag, "_q_addr"},       q_addr,       0);
        check({tag, "_replay_valid"}, replay_valid, 0);
        check({tag, "_replay_addr"},  replay_addr,  0);
        check({tag, "_replay_tag"},   replay_tag,   0);
        check({tag, "_en_clear"},     en_clear,     0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1);
    end

    initial begin
        int clr;
        int n;
        reset        = 1'b1;
        enq_valid    = 1'b0;
        enq_addr     = '0;
        enq_tag      = '0;
        cancel       = 1'b0;
        replay_ready = 1'b0;
        hit_en       = 1'b0;
        hit_addr     = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        reset = 1'b0;

        // Single miss: query appears two cycles after the push, pops next edge.
        push_entry(32'h0000_1040, 4'd3, 1'b1);
        check("t1_count_after_push", count, 1);
        check("t1_q_not_yet", q_addr, 0);
        tick();
        check("t1_q_addr_2cyc", q_addr, 32'h0000_1040);
        tick();
        check("t1_count_popped", count, 0);
        check("t1_q_addr_idle", q_addr, 0);
        check("t1_no_replay", replay_valid, 0);
        check("t1_no_clear", clear_seen, 0);

        // Hit on the middle of three entries, delayed replay acceptance.
        hit_addr = 32'h200;
        hit_en   = 1'b1;
        exp_replay.push_back({32'h200, 4'd2});
        push_entry(32'h100, 4'd1, 1'b1);
        push_entry(32'h200, 4'd2, 1'b1);
        push_entry(32'h300, 4'd5, 1'b1);
        wait_replay();
        check("t2_replay_addr", replay_addr, 32'h200);
        check("t2_replay_tag", replay_tag, 2);
        clr = clear_seen;
        repeat (3) begin
            tick();
            check("t2_hold_valid", replay_valid, 1);
            check("t2_hold_addr", replay_addr, 32'h200);
            check("t2_hold_no_clear", en_clear, 0);
        end
        replay_ready = 1'b1;
        tick();
        replay_ready = 1'b0;
        check("t2_clear_pulse", en_clear, 1);
        check("t2_valid_dropped", replay_valid, 0);
        check("t2_no_query_in_clear", q_addr, 0);
        tick();
        check("t2_clear_gone", en_clear, 0);
        check("t2_next_query", q_addr, 32'h300);
        tick();
        check("t2_drained", count, 0);
        check("t2_clear_cycles", clear_seen - clr, 1);
        hit_en = 1'b0;

        // Fill to DEPTH while stalled in REPLAY, reject a 9th, then stream 20 through with wrap.
        hit_addr = 32'hA00;
        hit_en   = 1'b1;
        exp_replay.push_back({32'hA00, 4'hA});
        push_entry(32'hA00, 4'hA, 1'b1);
        wait_replay();
        for (int i = 0; i < DEPTH; i++) push_entry(32'h1000 + 32'(i * 16), 4'(i), 1'b1);
        check("t3_full_count", count, DEPTH);
        check("t3_full_not_ready", enq_ready, 0);
        check("t3_still_replay", replay_valid, 1);
        enq_valid = 1'b1;
        enq_addr  = 32'hDEAD0;
        enq_tag   = 4'hF;
        tick();
        enq_valid = 1'b0;
        check("t3_ninth_rejected", count, DEPTH);
        clr = clear_seen;
        replay_ready = 1'b1;
        tick();
        replay_ready = 1'b0;
        for (int i = 0; i < 20; i++) push_entry(32'h2000 + 32'(i * 16), 4'(i), 1'b1);
        wait_idle();
        check("t3_all_queried", exp_query.size(), 0);
        check("t3_count_zero", count, 0);
        check("t3_one_clear", clear_seen - clr, 1);
        hit_en = 1'b0;

        // Cancel in REPLAY together with the replay handshake.
        hit_addr = 32'hB00;
        hit_en   = 1'b1;
        push_entry(32'hB00, 4'h1, 1'b1);
        push_entry(32'hB40, 4'h2, 1'b0);
        wait_replay();
        clr = clear_seen;
        cancel       = 1'b1;
        replay_ready = 1'b1;
        tick();
        cancel       = 1'b0;
        replay_ready = 1'b0;
        check("t4_count_flushed", count, 0);
        check("t4_replay_dropped", replay_valid, 0);
        check("t4_idle", busy, 0);
        check("t4_no_clear_now", en_clear, 0);
        repeat (4) tick();
        check("t4_no_clear_later", clear_seen - clr, 0);
        hit_en = 1'b0;

        // Cancel together with an enqueue while two entries are held.
        hit_addr = 32'hC00;
        hit_en   = 1'b1;
        push_entry(32'hC00, 4'h3, 1'b1);
        wait_replay();
        push_entry(32'hC40, 4'h4, 1'b0);
        push_entry(32'hC80, 4'h5, 1'b0);
        check("t5_holding_two", count, 2);
        cancel    = 1'b1;
        enq_valid = 1'b1;
        enq_addr  = 32'hCC0;
        enq_tag   = 4'h7;
        tick();
        cancel    = 1'b0;
        enq_valid = 1'b0;
        check("t5_count_flushed", count, 0);
        check("t5_idle", busy, 0);
        repeat (5) tick();
        check("t5_enq_dropped", count, 0);
        check("t5_no_stray_query", exp_query.size(), 0);
        hit_en = 1'b0;

        // Asynchronous reset between clock edges while in CHECK.
        push_entry(32'hD00, 4'h8, 1'b1);
        push_entry(32'hD40, 4'h9, 1'b1);
        push_entry(32'hD80, 4'hB, 1'b1);
        n = 0;
        while (q_addr == 0 && n < 20) begin
            tick();
            n++;
        end
        check("t6_in_check", q_addr != 0, 1);
        #2;
        reset = 1'b1;
        #1;
        check_reset_values("t6_async");
        exp_query.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("sb_replay_drained", exp_replay.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/commit_snoopissue.md
Name: commit_snoopissue

Overview:
- Query-side counterpart of the commit snoop table.
- Buffers speculatively executed load addresses, tagged with their ROB tag, and presents them one at a time on the snoop table's query interface (q_addr/q_hit).
- On a hit, issues a replay request for the offending load, then pulses en_clear back to the snoop table.
- Sits between the load-completion path and the commit/flush logic.

Parameters:
- DEPTH, 8, number of pending-load entries; power of two, minimum 2.
- TAG_W, 4, width of the ROB tag carried per entry.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- enq_valid  in  1  load-completion path offers an entry.
- enq_ready  out  1  entry accepted when enq_valid & enq_ready.
- enq_addr  in  32  load byte address.
- enq_tag  in  TAG_W  load ROB tag.
- cancel  in  1  pipeline flush; discards all pending work.
- q_addr  out  32  snoop query address to the snoop table.
- q_hit  in  1  snoop table hit for q_addr; combinational, same cycle.
- replay_valid  out  1  replay request pending.
- replay_ready  in  1  commit logic accepts the replay.
- replay_addr  out  32  address of the hitting load.
- replay_tag  out  TAG_W  ROB tag of the hitting load.
- en_clear  out  1  one-cycle clear pulse to the snoop table.
- count  out  $clog2(DEPTH)+1  number of buffered entries.
- busy  out  1  state != IDLE or count != 0.

Behaviour:
- Reset values: FIFO empty, state IDLE, enq_ready=1, replay_valid=0, replay_addr=0, replay_tag=0, en_clear=0, count=0, busy=0, q_addr=0.
- FIFO:
  - Circular buffer with rd/wr pointers of $clog2(DEPTH) bits; both wrap modulo DEPTH.
  - count tracks occupancy 0..DEPTH.
  - enq_ready = (count != DEPTH), registered-free; no same-cycle bypass when full, even if a pop occurs that cycle.
  - Simultaneous push and pop leave count unchanged.
- q_addr = head entry address when state==CHECK and count!=0, else 0.
- FSM states: IDLE, CHECK, REPLAY, CLEAR.
  - IDLE: if count!=0, go to CHECK next cycle. A push into an empty FIFO therefore takes 2 cycles to reach the query (1 cycle write, 1 cycle IDLE->CHECK).
  - CHECK:
    - Sample q_hit for the head each cycle.
    - Miss: pop head; stay in CHECK if count after pop is nonzero, else go to IDLE. Throughput is one query per cycle.
    - Hit: pop head, latch its addr/tag into replay_addr/replay_tag, go to REPLAY.
  - REPLAY: replay_valid=1, with addr/tag held stable. When replay_ready=1, go to CLEAR; replay_valid drops the next cycle.
  - CLEAR: en_clear=1 for exactly this cycle. Next state is CHECK if count!=0, else IDLE. No query is made in this cycle.
- Enqueue continues in every state while not full; pops occur only in CHECK.
- Address compare granularity is owned by the snoop table (cache line, bits [31:6]). This block passes the full 32-bit address unmodified.
- cancel, in any state:
  - Next cycle: FIFO emptied (pointers=0, count=0), state=IDLE, replay_valid=0.
  - An enq in the same cycle as cancel is dropped.
  - A replay handshake in the same cycle as cancel is ignored, and no en_clear follows.
  - en_clear is never asserted in the cycle after cancel.
- Reset asserted mid-operation: all state returns to reset values asynchronously. Any in-flight replay is lost; no en_clear is issued.

Decomposition:
- Shared package commit_pkg holds:
  - SNOOP_LINE_LSB = 6;
  - the FSM state encoding (2-bit enum, IDLE=0, CHECK=1, REPLAY=2, CLEAR=3);
  - the entry struct {addr[31:0], tag[TAG_W-1:0]}.
- One sub-module is natural: commit_snoopissue_fifo, the generic DEPTH-entry FIFO providing push/pop/head/count/flush.
- The FSM and replay registers stay in the top module.

Test Plan:
- Reset, then push addr 0x0000_1040/tag 3 with q_hit forced 0 -> q_addr=0x0000_1040 exactly 2 cycles after the push; popped the next edge; count returns 0; replay_valid and en_clear stay 0.
- Push 3 entries (0x100, 0x200, 0x300) back-to-back with q_hit=1 only while q_addr==0x200:
  - replay_valid=1 with replay_addr=0x200 and the matching tag;
  - replay_ready held 0 for 3 cycles, then 1 -> en_clear high for exactly 1 cycle after the handshake;
  - 0x300 queried the cycle after CLEAR.
- Fill to DEPTH=8 with q_hit=0 and the FSM stalled in REPLAY (replay_ready=0) -> enq_ready=0, count=8; a 9th enq_valid is not accepted. Push/pop wrap-around over 20 entries preserves FIFO order.
- Assert cancel during REPLAY with replay_ready=1 in the same cycle -> next cycle count=0, state IDLE, replay_valid=0; en_clear never pulses.
- Assert cancel together with enq_valid while holding 2 entries -> count=0 next cycle; the enqueued entry is never queried.
- Assert reset asynchronously mid-CHECK (between clock edges) -> all outputs at reset values immediately, before the next clock edge.
